pit_irq_ctrl: RTL and testbench



---
 rtl/pit_irq_ctrl_pkg.sv | 14 +
 rtl/pit_irq_ctrl_sat_counter.sv | 31 +++
 rtl/pit_irq_ctrl.sv | 109 ++++++++++
 tb/tb_pit_irq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pit_irq_ctrl_pkg.sv
// Shared definitions for the timer interrupt controller: state encoding and
// default counter widths.
package pit_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVICE = 2'd2
    } pit_state_t;

    localparam int DEF_COUNT_W = 16;
    localparam int DEF_MISS_W  = 8;

endpackage

// File: rtl/pit_irq_ctrl_sat_counter.sv
// Event counter with synchronous clear; either wraps or holds at all-ones
// depending on sat_en.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             sat_en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic             at_max;

    assign at_max = &count_reg;
    assign count  = count_reg;

    // Clear wins over increment so a clear coincident with an event yields 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !(sat_en && at_max)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pit_irq_ctrl.sv
// Turns the timer's one-cycle interrupt pulse into a sticky, maskable level
// cleared by a 4-phase ack handshake; counts total and lost events.
module pit_irq_ctrl
    import pit_irq_ctrl_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int MISS_W  = DEF_MISS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               irq_pulse,
    input  logic               irq_mask,
    input  logic               ack,
    input  logic               clear_counts,
    output logic               irq_out,
    output logic               pending,
    output logic               ack_resp,
    output logic [COUNT_W-1:0] event_count,
    output logic [MISS_W-1:0]  missed_count
);

    pit_state_t state_reg, state_next;
    logic       deferred_reg, deferred_next;
    logic       ack_armed_reg;
    logic       miss_inc;

    // An ack still high from before reset must be seen low once before it counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            deferred_reg  <= 1'b0;
            ack_armed_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            deferred_reg <= deferred_next;
            if (!ack) begin
                ack_armed_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        deferred_next = deferred_reg;
        miss_inc      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (irq_pulse) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (ack && ack_armed_reg) begin
                    state_next = ST_SERVICE;
                    if (irq_pulse) begin
                        deferred_next = 1'b1;
                    end
                end else if (irq_pulse) begin
                    miss_inc = 1'b1;
                end
            end
            ST_SERVICE: begin
                // Only one event can wait behind the one being serviced.
                if (irq_pulse) begin
                    if (deferred_reg) begin
                        miss_inc = 1'b1;
                    end else begin
                        deferred_next = 1'b1;
                    end
                end
                if (!ack) begin
                    state_next    = (deferred_reg || irq_pulse) ? ST_PENDING : ST_IDLE;
                    deferred_next = 1'b0;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                deferred_next = 1'b0;
            end
        endcase
    end

    assign pending  = (state_reg == ST_PENDING);
    assign irq_out  = pending & ~irq_mask;
    assign ack_resp = (state_reg == ST_SERVICE);

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_event_counter (
        .clk    (clk),
        .reset  (reset),
        .inc    (irq_pulse),
        .clr    (clear_counts),
        .sat_en (1'b0),
        .count  (event_count)
    );

    sat_counter #(
        .WIDTH (MISS_W)
    ) u_missed_counter (
        .clk    (clk),
        .reset  (reset),
        .inc    (miss_inc),
        .clr    (clear_counts),
        .sat_en (1'b1),
        .count  (missed_count)
    );

endmodule

// File: tb/tb_pit_irq_ctrl.sv
// Bench for pit_irq_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against an event-level reference model.
module tb_pit_irq_ctrl;

    localparam int COUNT_W = 16;
    localparam int MISS_W  = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               irq_pulse = 1'b0;
    logic               irq_mask = 1'b0;
    logic               ack = 1'b0;
    logic               clear_counts = 1'b0;
    logic               irq_out;
    logic               pending;
    logic               ack_resp;
    logic [COUNT_W-1:0] event_count;
    logic [MISS_W-1:0]  missed_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pit_irq_ctrl #(
        .COUNT_W (COUNT_W),
        .MISS_W  (MISS_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_pulse    (irq_pulse),
        .irq_mask     (irq_mask),
        .ack          (ack),
        .clear_counts (clear_counts),
        .irq_out      (irq_out),
        .pending      (pending),
        .ack_resp     (ack_resp),
        .event_count  (event_count),
        .missed_count (missed_count)
    );

    // Reference model: tracks whether an event is held, whether the host is
    // servicing it, how many events wait behind it, and plain integer tallies.
    bit m_held, m_serving, m_armed;
    int m_waiting, m_total, m_lost;

    task automatic model_edge(input bit p, input bit a, input bit c, input bit r);
        bit lost_now;
        bit host_ack;
        if (r) begin
            m_held = 0; m_serving = 0; m_armed = 0;
            m_waiting = 0; m_total = 0; m_lost = 0;
            return;
        end
        host_ack = a && m_armed;
        if (!a) m_armed = 1;
        lost_now = 0;
        if (m_serving) begin
            if (p) begin
                if (m_waiting < 1) m_waiting++;
                else lost_now = 1;
            end
            if (!a) begin
                m_serving = 0;
                m_held    = (m_waiting > 0);
                m_waiting = 0;
            end
        end else if (m_held) begin
            if (host_ack) begin
                m_held = 0; m_serving = 1;
                if (p) m_waiting = 1;
            end else if (p) begin
                lost_now = 1;
            end
        end else if (p) begin
            m_held = 1;
        end
        if (c) begin
            m_total = 0; m_lost = 0;
        end else begin
            if (p) m_total = (m_total + 1) % (1 << COUNT_W);
            if (lost_now && m_lost < (1 << MISS_W) - 1) m_lost++;
        end
    endtask

    function automatic logic [26:0] dut_vec();
        return {pending, irq_out, ack_resp, event_count, missed_count};
    endfunction

    task automatic check_vec(input string name, input logic [26:0] exp);
        logic [26:0] act;
        act = dut_vec();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got pend=%b irq=%b resp=%b ev=%0d miss=%0d, expected pend=%b irq=%b resp=%b ev=%0d miss=%0d",
                     name, act[26], act[25], act[24], act[23:8], act[7:0],
                     exp[26], exp[25], exp[24], exp[23:8], exp[7:0]);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare after it.
    task automatic step(input bit p, input bit m, input bit a, input bit c, input bit r);
        logic [26:0] exp;
        @(negedge clk);
        irq_pulse = p; irq_mask = m; ack = a; clear_counts = c; reset = r;
        @(posedge clk);
        model_edge(p, a, c, r);
        #1;
        exp = {m_held && !m_serving, m_held && !m_serving && !m, m_serving,
               COUNT_W'(m_total), MISS_W'(m_lost)};
        check_vec("model", exp);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        p, m, a, c;
        logic        pend, irq, resp;
        logic [15:0] ev;
        logic [7:0]  miss;
    } vec_t;

    function automatic vec_t mk(input bit p, input bit m, input bit a, input bit c,
                                input bit pend, input bit irq, input bit resp,
                                input int ev, input int miss);
        vec_t v;
        v.p = p; v.m = m; v.a = a; v.c = c;
        v.pend = pend; v.irq = irq; v.resp = resp;
        v.ev = 16'(ev); v.miss = 8'(miss);
        return v;
    endfunction

    vec_t vecs[22];

    initial begin
        //             p  m  a  c   pend irq resp ev miss
        vecs[0]  = mk(0, 0, 0, 0,   0,  0,  0,   0, 0);
        vecs[1]  = mk(1, 0, 0, 0,   1,  1,  0,   1, 0);
        vecs[2]  = mk(0, 0, 0, 0,   1,  1,  0,   1, 0);
        vecs[3]  = mk(1, 0, 0, 0,   1,  1,  0,   2, 1);
        vecs[4]  = mk(0, 0, 1, 0,   0,  0,  1,   2, 1);
        vecs[5]  = mk(1, 0, 1, 0,   0,  0,  1,   3, 1);
        vecs[6]  = mk(1, 0, 1, 0,   0,  0,  1,   4, 2);
        vecs[7]  = mk(0, 0, 0, 0,   1,  1,  0,   4, 2);
        vecs[8]  = mk(0, 1, 0, 0,   1,  0,  0,   4, 2);
        vecs[9]  = mk(0, 1, 1, 0,   0,  0,  1,   4, 2);
        vecs[10] = mk(0, 1, 0, 0,   0,  0,  0,   4, 2);
        vecs[11] = mk(1, 1, 0, 0,   1,  0,  0,   5, 2);
        vecs[12] = mk(0, 0, 0, 0,   1,  1,  0,   5, 2);
        vecs[13] = mk(1, 0, 0, 1,   1,  1,  0,   0, 0);
        vecs[14] = mk(0, 0, 1, 0,   0,  0,  1,   0, 0);
        vecs[15] = mk(1, 0, 0, 0,   1,  1,  0,   1, 0);
        vecs[16] = mk(0, 0, 1, 0,   0,  0,  1,   1, 0);
        vecs[17] = mk(0, 0, 0, 0,   0,  0,  0,   1, 0);
        vecs[18] = mk(0, 0, 1, 0,   0,  0,  0,   1, 0);
        vecs[19] = mk(1, 0, 1, 0,   1,  1,  0,   2, 0);
        vecs[20] = mk(0, 0, 1, 0,   0,  0,  1,   2, 0);
        vecs[21] = mk(0, 0, 0, 0,   0,  0,  0,   2, 0);

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_vec("reset", 27'd0);

        // Directed table
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].p, vecs[i].m, vecs[i].a, vecs[i].c, 0);
            check_vec($sformatf("vec%0d", i),
                      {vecs[i].pend, vecs[i].irq, vecs[i].resp, vecs[i].ev, vecs[i].miss});
        end

        // Missed counter saturates after 300 unserviced pulses
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0);
        check_val("sat_missed", int'(missed_count), 255);
        check_val("sat_events", int'(event_count), 300);
        check_val("sat_pending", int'(pending), 1);

        // Clear coincident with a pulse
        step(1, 0, 0, 1, 0);
        check_val("clr_events", int'(event_count), 0);
        check_val("clr_missed", int'(missed_count), 0);

        // Reset during SERVICE with ack held: no re-entry until ack falls
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check_val("svc_enter", int'(ack_resp), 1);
        step(0, 0, 1, 0, 1);
        check_vec("svc_reset", 27'd0);
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        check_val("no_reentry_resp", int'(ack_resp), 0);
        check_val("no_reentry_pend", int'(pending), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check_val("rearmed_resp", int'(ack_resp), 1);
        step(0, 0, 0, 0, 0);
        check_val("rearmed_idle", int'(pending | ack_resp), 0);

        // Event counter wraps after 2^16+1 pulses
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < (1 << COUNT_W) + 1; i++) step(1, 0, 0, 0, 0);
        check_val("wrap_events", int'(event_count), 1);
        check_val("wrap_missed", int'(missed_count), 255);

        // Randomized traffic against the model
        step(0, 0, 0, 0, 1);
        begin
            bit a_lvl;
            a_lvl = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) a_lvl = ~a_lvl;
                step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, a_lvl,
                     $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
